// File: rtl/sistema_sensor_pio_in.sv
// Avalon-MM input PIO: synchronises and debounces WIDTH async lines, captures
// selected edges into a write-1-to-clear register and raises a maskable level IRQ.
module sistema_sensor_pio_in #(
  parameter int WIDTH      = 10,
  parameter int DEB_CYCLES = 4,
  parameter int EDGE_TYPE  = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int CW = (DEB_CYCLES > 0) ? $clog2(DEB_CYCLES + 1) : 1;

  logic [WIDTH-1:0] s1, s2, stable, stable_d, edgecap, irqmask, ev, clr;
  logic [31:0]      rd_mux;
  logic             wr, rd;
  logic             unused_wdata;

  assign wr           = chipselect & ~write_n;
  assign rd           = chipselect & ~read_n;
  assign unused_wdata = &{1'b0, writedata};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= in_port;
      s2 <= s1;
    end
  end

  // A lane accepts a new level only after DEB_CYCLES consecutive differing samples.
  generate
    if (DEB_CYCLES == 0) begin : g_bypass
      assign stable = s2;
    end else begin : g_deb
      for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        logic [CW-1:0] cnt;
        logic          st;
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            cnt <= '0;
            st  <= 1'b0;
          end else if (s2[i] == st) begin
            cnt <= '0;
          end else if (cnt == CW'(DEB_CYCLES - 1)) begin
            st  <= s2[i];
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        assign stable[i] = st;
      end
    end

    if (EDGE_TYPE == 0) begin : g_rise
      assign ev = stable & ~stable_d;
    end else if (EDGE_TYPE == 1) begin : g_fall
      assign ev = ~stable & stable_d;
    end else begin : g_any
      assign ev = stable ^ stable_d;
    end
  endgenerate

  assign clr = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux[WIDTH-1:0] = stable;
      2'd2:    rd_mux[WIDTH-1:0] = irqmask;
      2'd3:    rd_mux[WIDTH-1:0] = edgecap;
      default: rd_mux = '0;
    endcase
  end

  // New edges win over a simultaneous write-1-to-clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_d <= '0;
      edgecap  <= '0;
      irqmask  <= '0;
      irq      <= 1'b0;
      readdata <= '0;
    end else begin
      stable_d <= stable;
      edgecap  <= ev | (edgecap & ~clr);
      if (wr && address == 2'd2) irqmask <= writedata[WIDTH-1:0];
      irq      <= |(edgecap & irqmask);
      readdata <= rd ? rd_mux : '0;
    end
  end

endmodule

// File: tb/tb_sistema_sensor_pio_in.sv
// Bench: three DUTs (rise/fall/any edge) share bus and inputs; a cycle model
// built from the run-length debounce rule predicts every readdata/irq.
module tb_sistema_sensor_pio_in;
  localparam int W   = 10;
  localparam int DEB = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [1:0]       address;
  logic             chipselect, read_n, write_n;
  logic [31:0]      writedata;
  logic [W-1:0]     in_port;
  logic [2:0][31:0] rdata;
  logic [2:0]       irq;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      sistema_sensor_pio_in #(.WIDTH(W), .DEB_CYCLES(DEB), .EDGE_TYPE(g)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .read_n(read_n), .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rdata[g]), .irq(irq[g])
      );
    end
  endgenerate

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a line's accepted level flips once the synchronised sample
  // has disagreed with it for DEB consecutive cycles.
  logic [W-1:0]     m_s1, m_s2, m_st, m_std, m_mask;
  logic [2:0][W-1:0] m_cap;
  logic [2:0][31:0] m_rd;
  logic [2:0]       m_irq;
  int               m_run [W];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_s1 <= '0; m_s2 <= '0; m_st <= '0; m_std <= '0; m_mask <= '0;
      m_cap <= '0; m_rd <= '0; m_irq <= '0;
      for (int i = 0; i < W; i++) m_run[i] <= 0;
    end else begin : m_upd
      logic [W-1:0] st_n, clr, ev;
      clr  = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
      st_n = m_st;
      for (int i = 0; i < W; i++) begin
        if (m_s2[i] !== m_st[i]) begin
          if (m_run[i] + 1 == DEB) begin
            st_n[i] = m_s2[i];
            m_run[i] <= 0;
          end else m_run[i] <= m_run[i] + 1;
        end else m_run[i] <= 0;
      end
      for (int g = 0; g < 3; g++) begin
        ev = (g == 0) ? (m_st & ~m_std) : (g == 1) ? (~m_st & m_std) : (m_st ^ m_std);
        m_cap[g] <= ev | (m_cap[g] & ~clr);
        m_irq[g] <= |(m_cap[g] & m_mask);
        if (chipselect && !read_n)
          case (address)
            2'd0: m_rd[g] <= 32'(m_st);
            2'd1: m_rd[g] <= '0;
            2'd2: m_rd[g] <= 32'(m_mask);
            default: m_rd[g] <= 32'(m_cap[g]);
          endcase
        else m_rd[g] <= '0;
      end
      if (chipselect && !write_n && address == 2'd2) m_mask <= writedata[W-1:0];
      m_st  <= st_n;
      m_std <= m_st;
      m_s2  <= m_s1;
      m_s1  <= in_port;
    end
  end

  always @(negedge clk) begin
    if (chk_en)
      for (int g = 0; g < 3; g++) begin
        chk("model_rd", rdata[g], m_rd[g]);
        chk("model_irq", 32'(irq[g]), 32'(m_irq[g]));
      end
  end

  // One bus cycle, entered and left at a falling edge.
  task automatic bus(input logic do_rd, input logic do_wr, input logic [1:0] a,
                     input logic [31:0] d);
    chipselect = 1'b1; read_n = !do_rd; write_n = !do_wr; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
  endtask

  initial begin
    chipselect = 0; read_n = 1; write_n = 1; address = 0; writedata = 0;
    in_port = '1; reset_n = 0;
    repeat (3) @(negedge clk);
    chk_en = 1;
    for (int g = 0; g < 3; g++) begin
      chk("rst_rd", rdata[g], 32'h0);
      chk("rst_irq", 32'(irq[g]), 32'h0);
    end
    reset_n = 1;
    repeat (5) @(negedge clk);
    bus(1, 0, 0, 0); chk("t1_data_early", rdata[0], 32'h0);
    bus(1, 0, 0, 0); chk("t1_data", rdata[0], 32'h3FF);
    in_port = '0; repeat (10) @(negedge clk);
    bus(0, 1, 3, '1);

    // glitch vs. accepted pulse on bit0
    in_port = 1; repeat (3) @(negedge clk); in_port = 0; repeat (10) @(negedge clk);
    bus(1, 0, 0, 0); chk("t2_glitch_data", rdata[0], 32'h0);
    bus(1, 0, 3, 0); chk("t2_glitch_edge", rdata[0], 32'h0);
    in_port = 1; repeat (6) @(negedge clk); in_port = 0;
    bus(1, 0, 0, 0); chk("t2_pulse_data", rdata[0], 32'h1);
    repeat (10) @(negedge clk);
    bus(1, 0, 0, 0); chk("t2_pulse_release", rdata[0], 32'h0);
    bus(1, 0, 3, 0); chk("t2_pulse_edge", rdata[0], 32'h1);

    // capture and IRQ masking
    bus(0, 1, 3, '1); bus(0, 1, 2, 32'h1);
    in_port = 1; repeat (8) @(negedge clk);
    bus(1, 0, 3, 0); chk("t3_edge", rdata[0], 32'h1); chk("t3_irq", 32'(irq[0]), 32'h1);
    in_port = 3; repeat (8) @(negedge clk);
    bus(1, 0, 3, 0); chk("t3_edge2", rdata[0], 32'h3); chk("t3_irq2", 32'(irq[0]), 32'h1);

    // clear, then clear colliding with a fresh edge
    bus(0, 1, 3, 32'h1); chk("t4_irq_lag", 32'(irq[0]), 32'h1);
    @(negedge clk); chk("t4_irq_clr", 32'(irq[0]), 32'h0);
    bus(1, 0, 3, 0); chk("t4_edge_clr", rdata[0], 32'h2);
    in_port = 2; repeat (8) @(negedge clk);
    in_port = 3; repeat (6) @(negedge clk);
    bus(0, 1, 3, 32'h1);
    @(negedge clk); chk("t4_collide_irq", 32'(irq[0]), 32'h1);
    bus(1, 0, 3, 0); chk("t4_collide_edge", rdata[0], 32'h3);

    // edge type selection on bit9
    bus(0, 1, 2, 0); bus(0, 1, 3, '1);
    in_port = 10'h203; repeat (10) @(negedge clk);
    bus(1, 0, 3, 0);
    chk("t5_rise_e0", rdata[0], 32'h200); chk("t5_rise_e1", rdata[1], 32'h0);
    chk("t5_rise_e2", rdata[2], 32'h200);
    in_port = 10'h003; repeat (10) @(negedge clk);
    bus(1, 0, 3, 0);
    chk("t5_fall_e0", rdata[0], 32'h200); chk("t5_fall_e1", rdata[1], 32'h200);
    chk("t5_fall_e2", rdata[2], 32'h200);

    // register map
    bus(0, 1, 0, 32'h155); bus(0, 1, 1, 32'h155);
    bus(1, 0, 0, 0); chk("t6_data", rdata[0], 32'h3);
    bus(1, 0, 1, 0); chk("t6_rsvd", rdata[0], 32'h0);
    bus(0, 1, 2, 32'h2AA); bus(1, 0, 2, 0); chk("t6_mask", rdata[0], 32'h2AA);
    bus(0, 1, 2, '1); bus(1, 0, 2, 0); chk("t6_mask_upper", rdata[0], 32'h3FF);
    bus(1, 1, 2, 32'h055); chk("t6_rw_old", rdata[0], 32'h3FF);
    bus(1, 0, 2, 0); chk("t6_rw_new", rdata[0], 32'h055);

    // randomised traffic and input activity
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(3) == 0) in_port = in_port ^ (W'(1) << $urandom_range(W - 1));
      chipselect = 1'($urandom_range(1));
      read_n     = 1'($urandom_range(1));
      write_n    = ($urandom_range(3) != 0);
      address    = 2'($urandom_range(3));
      writedata  = $urandom;
      @(negedge clk);
      if (c == 1500) begin
        #2 reset_n = 0;
        repeat (2) @(negedge clk);
        for (int g = 0; g < 3; g++) chk("mid_rst_irq", 32'(irq[g]), 32'h0);
        #2 reset_n = 1;
      end
    end
    chipselect = 0; read_n = 1; write_n = 1;
    repeat (20) @(negedge clk);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
